// File: rtl/lms_adapt_engine_if.sv
// Handshake and result bus for the LMS adaptive FIR engine.
// The upstream sample source / result consumer drives the master side,
// the engine itself is the slave.
interface lms_adapt_engine_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] x_in;
  logic signed [7:0] d_in;
  logic              adapt_en;
  logic signed [7:0] y_out;
  logic signed [7:0] e_out;
  logic              out_valid;
  logic              busy;

  modport master (
    output in_valid, x_in, d_in, adapt_en,
    input  in_ready, y_out, e_out, out_valid, busy
  );

  modport slave (
    input  in_valid, x_in, d_in, adapt_en,
    output in_ready, y_out, e_out, out_valid, busy
  );
endinterface

// File: rtl/lms_adapt_engine.sv
// Sequential 8-tap LMS adaptive FIR engine.
// One shared multiplier serves both the 8-cycle MAC pass that forms
// y = sum(w*x) >>> FRAC and the 8-cycle weight-update pass
// w_k += (e*x_k) >>> MU_SHIFT. Weights persist across samples.
module lms_adapt_engine #(
  parameter int W_W      = 16,
  parameter int FRAC     = 7,
  parameter int MU_SHIFT = 10
) (
  input logic              clk,
  input logic              rst,
  lms_adapt_engine_if.slave bus
);

  localparam int ACC_W  = 28;
  localparam int PROD_W = W_W + 8;

  localparam logic signed [ACC_W-1:0] S8_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] S8_MIN = ACC_W'(-128);
  localparam logic signed [W_W:0]     SW_MAX = (W_W+1)'((64'sd1 <<< (W_W-1)) - 64'sd1);
  localparam logic signed [W_W:0]     SW_MIN = -SW_MAX - (W_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_ERR,
    S_UPD
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [2:0]              r_k;
  logic signed [7:0]       r_x [8];
  logic signed [W_W-1:0]   r_w [8];
  logic signed [7:0]       r_d;
  logic signed [7:0]       r_y;
  logic signed [7:0]       r_e;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_out_valid;

  logic                    w_accept;
  logic signed [7:0]       w_xk;
  logic signed [W_W-1:0]   w_mul_a;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] w_step;
  logic signed [W_W:0]     w_wsum;
  logic signed [7:0]       w_y;
  logic signed [8:0]       w_diff;
  logic signed [7:0]       w_e;

  // Clamp a wide signed value into the 8-bit output range.
  function automatic logic signed [7:0] sat8(input logic signed [ACC_W-1:0] v);
    if (v > S8_MAX)      return 8'sh7f;
    else if (v < S8_MIN) return 8'sh80;
    else                 return v[7:0];
  endfunction

  // Clamp a one-bit-wider weight sum back into the weight range.
  function automatic logic signed [W_W-1:0] satw(input logic signed [W_W:0] v);
    if (v > SW_MAX)      return SW_MAX[W_W-1:0];
    else if (v < SW_MIN) return SW_MIN[W_W-1:0];
    else                 return v[W_W-1:0];
  endfunction

  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  // Shared multiplier: weight during MAC, registered error during UPD.
  assign w_xk    = r_x[r_k];
  assign w_mul_a = (r_state == S_UPD) ? W_W'(r_e) : r_w[r_k];
  assign w_prod  = PROD_W'(w_mul_a) * PROD_W'(w_xk);

  // Update step is tiny (|e*x| <= 2^14), so narrowing it before the add is lossless.
  assign w_step = w_prod >>> MU_SHIFT;
  assign w_wsum = (W_W+1)'(r_w[r_k]) + (W_W+1)'(w_step);

  // Output and error; the subtraction is done at 9 bits so it never wraps.
  assign w_y    = sat8(r_acc >>> FRAC);
  assign w_diff = 9'(r_d) - 9'(w_y);
  assign w_e    = sat8(ACC_W'(w_diff));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: IDLE -> MAC(8) -> ERR -> [UPD(8)] -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_nxt = S_MAC;
      S_MAC:   if (r_k == 3'd7) w_state_nxt = S_ERR;
      S_ERR:   w_state_nxt = bus.adapt_en ? S_UPD : S_IDLE;
      S_UPD:   if (r_k == 3'd7) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: window capture, accumulation, result registers and weight update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_d         <= '0;
      r_y         <= '0;
      r_e         <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        r_x[k] <= '0;
        r_w[k] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        // accept: shift window, capture desired sample, clear accumulator
        S_IDLE: begin
          if (w_accept) begin
            for (int k = 7; k > 0; k--) r_x[k] <= r_x[k-1];
            r_x[0] <= bus.x_in;
            r_d    <= bus.d_in;
            r_acc  <= '0;
            r_k    <= '0;
          end
        end
        // MAC: one tap per cycle; r_k wraps back to 0 after tap 7
        S_MAC: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_k   <= r_k + 3'd1;
        end
        // ERR: register y/e and pulse out_valid
        S_ERR: begin
          r_y         <= w_y;
          r_e         <= w_e;
          r_out_valid <= 1'b1;
        end
        // UPD: one weight per cycle using the same window as the MAC pass
        S_UPD: begin
          r_w[r_k] <= satw(w_wsum);
          r_k      <= r_k + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.y_out     = r_y;
  assign bus.e_out     = r_e;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_lms_adapt_engine.sv
// Directed bench for lms_adapt_engine with an integer reference model
// feeding a scoreboard queue of expected (y, e) pairs.
module tb_lms_adapt_engine;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;

  lms_adapt_engine_if bus ();

  lms_adapt_engine #(.W_W(16), .FRAC(7), .MU_SHIFT(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = clk_en ? ~clk : 1'b0;

  typedef struct {
    int y;
    int e;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   mx[8];
  int   mw[8];
  time  t_acc = 0;
  time  t_prev = 0;
  bit   chk_conv = 1'b0;

  task automatic chk(input string tag, input integer obs, input integer req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      mx[k] = 0;
      mw[k] = 0;
    end
    q.delete();
  endtask

  task automatic model_push(input int x, input int d, input bit ad);
    int acc;
    int y;
    int e;
    for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    acc = 0;
    for (int k = 0; k < 8; k++) acc += mw[k] * mx[k];
    y = clamp(acc >>> 7, -128, 127);
    e = clamp(d - y, -128, 127);
    if (ad) begin
      for (int k = 0; k < 8; k++) mw[k] = clamp(mw[k] + ((e * mx[k]) >>> 10), -32768, 32767);
    end
    q.push_back('{y: y, e: e});
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic send(input int x, input int d, input bit ad, input bit keep);
    int n;
    n = 0;
    bus.x_in     = 8'(x);
    bus.d_in     = 8'(d);
    bus.adapt_en = ad;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait_ok", int'(n < 40), 1);
    if (n < 40) model_push(x, d, ad);
    @(posedge clk);
    t_prev = t_acc;
    t_acc  = $time;
    @(negedge clk);
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait_ok", int'(n < 40), 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_weights_model();
    for (int k = 0; k < 8; k++) chk($sformatf("w%0d_model", k), int'(dut.r_w[k]), mw[k]);
  endtask

  // Scoreboard: every out_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      chk("out_valid_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_t ex;
        ex = q.pop_front();
        chk("y_out", int'(bus.y_out), ex.y);
        chk("e_out", int'(bus.e_out), ex.e);
        chk("latency", int'($time - t_acc), 95);
        chk("in_ready_with_ov", int'(bus.in_ready), int'(!bus.adapt_en));
        if (chk_conv) begin
          chk("conv_abs_e_le16", int'(bus.e_out >= -16 && bus.e_out <= 16), 1);
        end
      end
    end
  end

  initial begin
    int ej;
    bus.in_valid = 1'b0;
    bus.x_in     = '0;
    bus.d_in     = '0;
    bus.adapt_en = 1'b0;
    model_clear();

    // Reset with no clock running
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_y_out", int'(bus.y_out), 0);
    chk("rst_e_out", int'(bus.e_out), 0);
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Zero weights, no adaptation; second sample held pending with junk while busy
    send(100, 50, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.x_in = 8'($urandom_range(0, 255));
      chk("busy_while_mac", int'(bus.busy), 1);
      @(negedge clk);
    end
    send(20, -10, 1'b0, 1'b0);
    chk("spacing_no_adapt", int'(t_acc - t_prev), 100);
    wait_idle();
    chk_weights_model();

    // Single adaptation step from reset
    do_reset();
    @(negedge clk);
    send(64, 64, 1'b1, 1'b1);
    while (!bus.in_ready && (($time - t_acc) < 400)) @(negedge clk);
    chk("w0_after_step", int'(dut.r_w[0]), 4);
    for (int k = 1; k < 8; k++) chk($sformatf("w%0d_after_step", k), int'(dut.r_w[k]), 0);
    send(64, 64, 1'b1, 1'b0);
    chk("spacing_adapt", int'(t_acc - t_prev), 180);
    wait_idle();
    chk_weights_model();

    // Saturation of e: w0 = 4, x = -128, d = 127 -> y = -4, e clamps to 127
    do_reset();
    @(negedge clk);
    send(64, 64, 1'b1, 1'b0);
    wait_idle();
    chk("sat_pre_w0", int'(dut.r_w[0]), 4);
    send(-128, 127, 1'b0, 1'b0);
    chk("sat_model_e", q[q.size()-1].e, 127);
    wait_idle();

    // Convergence over 300 samples
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      if (i == 280) chk_conv = 1'b1;
      send(64, 64, 1'b1, 1'b0);
    end
    wait_idle();
    chk_conv = 1'b0;
    chk_weights_model();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("w%0d_not_saturated", k),
          int'(dut.r_w[k] != 16'sh7fff && dut.r_w[k] != 16'sh8000), 1);
    end

    // Backpressure and abort by reset at E5
    do_reset();
    @(negedge clk);
    send(64, 64, 1'b1, 1'b0);
    wait_idle();
    send(10, 20, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ej = int'($urandom_range(0, 255));
      bus.x_in = 8'(ej);
      chk("in_ready_low_busy", int'(bus.in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_abort", int'(bus.in_ready), 1);
    chk("busy_after_abort", int'(bus.busy), 0);
    for (int k = 0; k < 8; k++) chk($sformatf("w%0d_after_abort", k), int'(dut.r_w[k]), 0);
    repeat (15) @(negedge clk);

    // Normal operation after abort
    send(-50, 30, 1'b0, 1'b0);
    wait_idle();
    chk("scoreboard_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lms_adapt_engine.md
# lms_adapt_engine

Sequential 8-tap LMS adaptive FIR engine that sits directly downstream of the 8-sample delay line in the adaptive-filter datapath. Each accepted signed 8-bit sample enters an internal 8-deep tap window. A single shared multiplier then computes the filter output y over 8 cycles and forms the error e = d − y. When adaptation is enabled, it updates all 8 weights over a further 8 cycles. A valid/ready handshake paces upstream, and one out_valid pulse per sample delivers y and e.

## Interface
- W_W, 16: weight width, signed two's complement.
- FRAC, 7: weight fractional bits; y = Σ(w·x) >>> FRAC.
- MU_SHIFT, 10: step size; Δw_k = (e·x_k) >>> MU_SHIFT.

- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: x_in/d_in valid.
- in_ready, output, 1: engine can accept; high only in IDLE.
- x_in, input, 8: signed input sample.
- d_in, input, 8: signed desired sample, paired with x_in.
- adapt_en, input, 1: enable weight update; sampled in ERR.
- y_out, output, 8: signed filter output, saturated.
- e_out, output, 8: signed error d − y, saturated.
- out_valid, output, 1: one-cycle pulse when y_out/e_out update.
- busy, output, 1: equals ~in_ready.

## Operation
- Reset clears the state to IDLE, window x_0..x_7, weights w_0..w_7, accumulator, y_out, e_out, and out_valid to 0. in_ready is 1 and busy is 0.
- Accept = in_valid && in_ready. On accept:
  - The window shifts: x_k ← x_{k-1}, then x_0 ← x_in.
  - d_in is captured.
  - The accumulator is cleared.
  - The state goes IDLE→MAC.
- in_valid while busy is ignored. Upstream holds its data until it sees in_ready.
- MAC (8 cycles, k = 0..7): acc += w_k·x_k.
  - Each product is 24-bit signed.
  - The accumulator is 28-bit signed and cannot overflow.
  - After k = 7, the state goes to ERR.
- ERR (1 cycle):
  - y = sat8(acc >>> FRAC), with arithmetic shift (floor).
  - e = sat8(d − y), with the subtraction done at 9 bits.
  - y_out and e_out are registered and out_valid is set.
  - If adapt_en = 1, the state goes to UPD; otherwise it goes to IDLE.
- UPD (8 cycles, k = 0..7): w_k ← satW(w_k + ((e·x_k) >>> MU_SHIFT)).
  - e·x_k is 16-bit signed, shifted with floor.
  - After k = 7, the state goes to IDLE.
- Saturation clamps to [−128, 127] for sat8 and to [−2^(W_W−1), 2^(W_W−1)−1] for satW. There is no wrap-around anywhere.
- The window uses samples present at accept time. The update uses the same window as the MAC that produced e.
- Weights persist across samples and are cleared only by reset.

## Timing
- Edge E0 is the accepting edge.
  - MAC runs on edges E1–E8.
  - ERR registers outputs at E9, so out_valid is high for exactly the cycle E9–E10.
- adapt_en = 0:
  - The state returns to IDLE at E9, and in_ready is high in the same cycle as out_valid.
  - The next accept is possible at E10, giving a minimum sample spacing of 10 cycles.
- adapt_en = 1:
  - UPD runs on edges E10–E17, and the state is IDLE after E17.
  - The next accept is possible at E18, giving a minimum spacing of 18 cycles.
- y_out and e_out hold their value until the next ERR.
- rst asserted mid-MAC or mid-UPD immediately forces the full reset state.
  - No out_valid is issued for the aborted sample.
  - Partially updated weights are cleared.
- adapt_en changes outside ERR have no effect on the current sample.

## Test plan
- **Reset:**
  - Stimulus: assert rst mid-cycle with no clock.
  - Required response: outputs read in_ready = 1, busy = 0, out_valid = 0, y_out = 0, e_out = 0.
- **Zero weights, adapt_en = 0:**
  - Stimulus: accept x = 100, d = 50.
  - Required response: y = 0, e = 50, out_valid high exactly 9 edges after the accept edge; the next accept succeeds 10 edges after the first.
- **Single adapt step (MU_SHIFT = 10):**
  - Stimulus: from reset, send x = 64, d = 64.
  - Required response: y = 0, e = 64, w_0 = 4, all other weights 0; a second x = 64, d = 64 gives y = 2, e = 62; the 18-cycle spacing is enforced (in_valid held high is accepted only at E18).
- **Saturation:**
  - Stimulus: starting from w_0 = 4 with the other weights 0, set adapt_en = 0 and send x = −128, d = 127.
  - Required response: y = −4, e = 131 clamped to e_out = 127.
- **Convergence:**
  - Stimulus: 300 samples of x = 64, d = 64 with adapt_en = 1.
  - Required response: |e_out| ≤ 16 over the final 20 samples; no weight reaches a saturation bound.
- **Abort and backpressure:**
  - Stimulus: hold in_valid high during MAC with changing x_in, then pulse rst at E5 of a sample.
  - Required response: changing x_in is not accepted while busy; after the rst pulse there is no out_valid, all weights read 0, and in_ready = 1 on the first cycle after reset release.
